// File: rtl/rx_sys_ctrl.sv
// System controller between a UART receiver/transmitter, a register file and an ALU.
// It decodes command bytes, runs register-file and ALU accesses, and returns replies to the transmitter.
module rx_sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    TX_BUSY,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    output logic                    CLK_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OP_A     = 4'd5,
        OP_B     = 4'd6,
        ALU_FN   = 4'd7,
        ALU_WAIT = 4'd8,
        TX_LO    = 4'd9,
        TX_HI    = 4'd10,
        TX_DONE  = 4'd11
    } state_t;

    // Per-byte transmit handshake: send, see busy rise, see busy fall.
    typedef enum logic [1:0] {
        TX_SEND    = 2'd0,
        TX_WAIT_HI = 2'd1,
        TX_WAIT_LO = 2'd2
    } tx_phase_t;

    state_t                  state_r, state_s;
    tx_phase_t               tx_phase_r, tx_phase_s;
    logic [DATA_WIDTH-1:0]   lo_byte_r, lo_byte_s;
    logic [DATA_WIDTH-1:0]   hi_byte_r, hi_byte_s;
    logic                    two_byte_r, two_byte_s;
    logic                    wr_en_s, rd_en_s, alu_en_s, clk_en_s, tx_d_vld_s;
    logic [ADDR_WIDTH-1:0]   address_s;
    logic [DATA_WIDTH-1:0]   wr_data_s, tx_p_data_s;
    logic [3:0]              alu_fun_s;

    // Next-state and next-output decode; strobes default low, data outputs hold.
    always_comb begin
        state_s     = state_r;
        tx_phase_s  = tx_phase_r;
        lo_byte_s   = lo_byte_r;
        hi_byte_s   = hi_byte_r;
        two_byte_s  = two_byte_r;
        wr_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        alu_en_s    = 1'b0;
        tx_d_vld_s  = 1'b0;
        clk_en_s    = CLK_EN;
        address_s   = Address;
        wr_data_s   = WrData;
        alu_fun_s   = ALU_FUN;
        tx_p_data_s = TX_P_DATA;

        case (state_r)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR) begin
                        state_s = WR_ADDR;
                    end else if (RX_P_DATA == CMD_RD) begin
                        state_s = RD_ADDR;
                    end else if (RX_P_DATA == CMD_ALU_OP) begin
                        state_s = OP_A;
                    end else if (RX_P_DATA == CMD_ALU_NP) begin
                        state_s = ALU_FN;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    address_s = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s   = WR_DATA;
                end else begin
                    state_s = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_s = RX_P_DATA;
                    wr_en_s   = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = WR_DATA;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    address_s = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_s   = 1'b1;
                    state_s   = RD_WAIT;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            RD_WAIT: begin
                if (RdData_Valid) begin
                    lo_byte_s  = RdData;
                    two_byte_s = 1'b0;
                    tx_phase_s = TX_SEND;
                    state_s    = TX_LO;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            OP_A: begin
                if (RX_D_VLD) begin
                    address_s = {ADDR_WIDTH{1'b0}};
                    wr_data_s = RX_P_DATA;
                    wr_en_s   = 1'b1;
                    state_s   = OP_B;
                end else begin
                    state_s = OP_A;
                end
            end
            OP_B: begin
                if (RX_D_VLD) begin
                    address_s = ADDR_WIDTH'(1'b1);
                    wr_data_s = RX_P_DATA;
                    wr_en_s   = 1'b1;
                    state_s   = ALU_FN;
                end else begin
                    state_s = OP_B;
                end
            end
            ALU_FN: begin
                if (RX_D_VLD) begin
                    alu_fun_s = RX_P_DATA[3:0];
                    alu_en_s  = 1'b1;
                    clk_en_s  = 1'b1;
                    state_s   = ALU_WAIT;
                end else begin
                    state_s = ALU_FN;
                end
            end
            ALU_WAIT: begin
                if (OUT_Valid) begin
                    lo_byte_s  = ALU_OUT[DATA_WIDTH-1:0];
                    hi_byte_s  = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                    two_byte_s = 1'b1;
                    clk_en_s   = 1'b0;
                    tx_phase_s = TX_SEND;
                    state_s    = TX_LO;
                end else begin
                    state_s = ALU_WAIT;
                end
            end
            TX_LO, TX_HI: begin
                case (tx_phase_r)
                    TX_SEND: begin
                        if (!TX_BUSY) begin
                            tx_p_data_s = (state_r == TX_HI) ? hi_byte_r : lo_byte_r;
                            tx_d_vld_s  = 1'b1;
                            tx_phase_s  = TX_WAIT_HI;
                        end else begin
                            tx_phase_s = TX_SEND;
                        end
                    end
                    TX_WAIT_HI: begin
                        if (TX_BUSY) begin
                            tx_phase_s = TX_WAIT_LO;
                        end else begin
                            tx_phase_s = TX_WAIT_HI;
                        end
                    end
                    TX_WAIT_LO: begin
                        if (!TX_BUSY) begin
                            tx_phase_s = TX_SEND;
                            if ((state_r == TX_LO) && two_byte_r) begin
                                state_s = TX_HI;
                            end else begin
                                state_s = TX_DONE;
                            end
                        end else begin
                            tx_phase_s = TX_WAIT_LO;
                        end
                    end
                    default: tx_phase_s = TX_SEND;
                endcase
            end
            TX_DONE: begin
                two_byte_s = 1'b0;
                state_s    = IDLE;
            end
            default: begin
                state_s    = IDLE;
                tx_phase_s = TX_SEND;
            end
        endcase
    end

    // State, capture and output registers; reset clears everything to zero.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= IDLE;
            tx_phase_r <= TX_SEND;
            lo_byte_r  <= {DATA_WIDTH{1'b0}};
            hi_byte_r  <= {DATA_WIDTH{1'b0}};
            two_byte_r <= 1'b0;
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            Address    <= {ADDR_WIDTH{1'b0}};
            WrData     <= {DATA_WIDTH{1'b0}};
            ALU_EN     <= 1'b0;
            ALU_FUN    <= 4'd0;
            CLK_EN     <= 1'b0;
            TX_P_DATA  <= {DATA_WIDTH{1'b0}};
            TX_D_VLD   <= 1'b0;
        end else begin
            state_r    <= state_s;
            tx_phase_r <= tx_phase_s;
            lo_byte_r  <= lo_byte_s;
            hi_byte_r  <= hi_byte_s;
            two_byte_r <= two_byte_s;
            WrEn       <= wr_en_s;
            RdEn       <= rd_en_s;
            Address    <= address_s;
            WrData     <= wr_data_s;
            ALU_EN     <= alu_en_s;
            ALU_FUN    <= alu_fun_s;
            CLK_EN     <= clk_en_s;
            TX_P_DATA  <= tx_p_data_s;
            TX_D_VLD   <= tx_d_vld_s;
        end
    end

endmodule

// File: tb/tb_rx_sys_ctrl.sv
// Directed bench for rx_sys_ctrl: command byte sequences, a simple transmitter busy model,
// and strobe monitors whose logs are compared against hand-computed values.
module tb_rx_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = 8'h00;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        OUT_Valid = 1'b0;
    logic        TX_BUSY;
    logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
    logic [3:0]  Address;
    logic [7:0]  WrData, TX_P_DATA;
    logic [3:0]  ALU_FUN;

    logic        busy_hold = 1'b0;
    int          tx_timer = 0;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, tx_cnt = 0;
    int overlap_cnt = 0, tx_busy_viol = 0, alu_no_clken = 0;
    logic [3:0] wr_addr_log [16];
    logic [7:0] wr_data_log [16];
    logic [3:0] rd_addr_log [16];
    logic [3:0] alu_fun_log [16];
    logic [7:0] tx_log      [16];
    int         tx_cyc_log  [16];

    rx_sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
        .TX_BUSY(TX_BUSY),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    // Transmitter model: busy for five cycles after each accepted byte.
    always @(posedge CLK) begin
        if (tx_timer > 0) tx_timer <= tx_timer - 1;
        else if (TX_D_VLD) tx_timer <= 5;
    end
    assign TX_BUSY = busy_hold | (tx_timer != 0);

    // Strobe monitor sampled on the falling edge.
    always @(negedge CLK) begin
        cyc++;
        if ((int'(WrEn) + int'(RdEn) + int'(ALU_EN) + int'(TX_D_VLD)) > 1) overlap_cnt++;
        if (WrEn) begin
            wr_addr_log[wr_cnt % 16] = Address;
            wr_data_log[wr_cnt % 16] = WrData;
            wr_cnt++;
        end
        if (RdEn) begin
            rd_addr_log[rd_cnt % 16] = Address;
            rd_cnt++;
        end
        if (ALU_EN) begin
            alu_fun_log[alu_cnt % 16] = ALU_FUN;
            if (!CLK_EN) alu_no_clken++;
            alu_cnt++;
        end
        if (TX_D_VLD) begin
            tx_log[tx_cnt % 16]     = TX_P_DATA;
            tx_cyc_log[tx_cnt % 16] = cyc;
            if (TX_BUSY) tx_busy_viol++;
            tx_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        for (int i = 0; i < 300 && tx_cnt < target; i++) @(negedge CLK);
    endtask

    task automatic alu_result(input logic [15:0] r);
        @(negedge CLK);
        ALU_OUT   = r;
        OUT_Valid = 1'b1;
        @(negedge CLK);
        OUT_Valid = 1'b0;
    endtask

    int wr0, rd0, alu0, tx0;

    initial begin
        // Reset state
        wait_cycles(2);
        check("rst_wren", {31'd0, WrEn}, 32'd0);
        check("rst_rden", {31'd0, RdEn}, 32'd0);
        check("rst_alu_en", {31'd0, ALU_EN}, 32'd0);
        check("rst_clk_en", {31'd0, CLK_EN}, 32'd0);
        check("rst_tx_vld", {31'd0, TX_D_VLD}, 32'd0);
        check("rst_address", {28'd0, Address}, 32'd0);
        check("rst_wrdata", {24'd0, WrData}, 32'd0);
        check("rst_tx_data", {24'd0, TX_P_DATA}, 32'd0);
        RST = 1'b1;
        wait_cycles(2);

        // RF write: AA,05,3C
        wr0 = wr_cnt; rd0 = rd_cnt; alu0 = alu_cnt; tx0 = tx_cnt;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        wait_cycles(4);
        check("wr_count", wr_cnt - wr0, 32'd1);
        check("wr_addr", {28'd0, wr_addr_log[wr0 % 16]}, 32'h5);
        check("wr_data", {24'd0, wr_data_log[wr0 % 16]}, 32'h3C);
        check("wr_no_rd", rd_cnt - rd0, 32'd0);
        check("wr_no_alu", alu_cnt - alu0, 32'd0);
        check("wr_no_tx", tx_cnt - tx0, 32'd0);
        check("wr_addr_hold", {28'd0, Address}, 32'h5);

        // RF read with transmitter busy until released: BB,05 -> 3C
        rd0 = rd_cnt; tx0 = tx_cnt;
        busy_hold = 1'b1;
        send_byte(8'hBB); send_byte(8'h05);
        wait_cycles(2);
        check("rd_count", rd_cnt - rd0, 32'd1);
        check("rd_addr", {28'd0, rd_addr_log[rd0 % 16]}, 32'h5);
        @(negedge CLK); RdData = 8'h3C; RdData_Valid = 1'b1;
        @(negedge CLK); RdData_Valid = 1'b0;
        wait_cycles(6);
        check("rd_tx_held", tx_cnt - tx0, 32'd0);
        busy_hold = 1'b0;
        wait_tx(tx0 + 1);
        check("rd_tx_count", tx_cnt - tx0, 32'd1);
        check("rd_tx_byte", {24'd0, tx_log[tx0 % 16]}, 32'h3C);
        wait_cycles(20);
        check("rd_tx_single", tx_cnt - tx0, 32'd1);

        // ALU with operands: CC,0A,03,00 -> 0x000D
        wr0 = wr_cnt; alu0 = alu_cnt; tx0 = tx_cnt;
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h00);
        wait_cycles(2);
        check("op_wr_count", wr_cnt - wr0, 32'd2);
        check("op_a_addr", {28'd0, wr_addr_log[wr0 % 16]}, 32'h0);
        check("op_a_data", {24'd0, wr_data_log[wr0 % 16]}, 32'h0A);
        check("op_b_addr", {28'd0, wr_addr_log[(wr0 + 1) % 16]}, 32'h1);
        check("op_b_data", {24'd0, wr_data_log[(wr0 + 1) % 16]}, 32'h03);
        check("op_alu_count", alu_cnt - alu0, 32'd1);
        check("op_alu_fun", {28'd0, alu_fun_log[alu0 % 16]}, 32'h0);
        check("op_clk_en_on", {31'd0, CLK_EN}, 32'd1);
        alu_result(16'h000D);
        wait_tx(tx0 + 2);
        check("op_tx_count", tx_cnt - tx0, 32'd2);
        check("op_tx_lo", {24'd0, tx_log[tx0 % 16]}, 32'h0D);
        check("op_tx_hi", {24'd0, tx_log[(tx0 + 1) % 16]}, 32'h00);
        check("op_tx_gap", {31'd0, (tx_cyc_log[(tx0 + 1) % 16] - tx_cyc_log[tx0 % 16]) > 6}, 32'd1);
        check("op_clk_en_off", {31'd0, CLK_EN}, 32'd0);
        wait_cycles(20);

        // Invalid byte then ALU without operands: 55, DD,02
        wr0 = wr_cnt; alu0 = alu_cnt; tx0 = tx_cnt;
        send_byte(8'h55);
        wait_cycles(2);
        send_byte(8'hDD); send_byte(8'h02);
        wait_cycles(2);
        check("np_alu_count", alu_cnt - alu0, 32'd1);
        check("np_alu_fun", {28'd0, alu_fun_log[alu0 % 16]}, 32'h2);
        check("np_no_wr", wr_cnt - wr0, 32'd0);
        alu_result(16'h1234);
        wait_tx(tx0 + 2);
        check("np_tx_lo", {24'd0, tx_log[tx0 % 16]}, 32'h34);
        check("np_tx_hi", {24'd0, tx_log[(tx0 + 1) % 16]}, 32'h12);
        wait_cycles(20);

        // Reset mid-command: AA,07, reset, 3C ignored, then a clean write
        wr0 = wr_cnt;
        send_byte(8'hAA); send_byte(8'h07);
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); RST = 1'b1;
        check("rst_mid_address", {28'd0, Address}, 32'h0);
        send_byte(8'h3C);
        wait_cycles(3);
        check("rst_mid_no_wr", wr_cnt - wr0, 32'd0);
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
        wait_cycles(3);
        check("rst_post_wr_count", wr_cnt - wr0, 32'd1);
        check("rst_post_wr_addr", {28'd0, wr_addr_log[wr0 % 16]}, 32'h2);
        check("rst_post_wr_data", {24'd0, wr_data_log[wr0 % 16]}, 32'h11);

        // Command byte during ALU_WAIT is discarded: DD,05, AA, result BEEF
        wr0 = wr_cnt; alu0 = alu_cnt; tx0 = tx_cnt;
        send_byte(8'hDD); send_byte(8'h05);
        send_byte(8'hAA);
        wait_cycles(2);
        check("disc_alu_fun", {28'd0, alu_fun_log[alu0 % 16]}, 32'h5);
        alu_result(16'hBEEF);
        wait_tx(tx0 + 2);
        check("disc_tx_count", tx_cnt - tx0, 32'd2);
        check("disc_tx_lo", {24'd0, tx_log[tx0 % 16]}, 32'hEF);
        check("disc_tx_hi", {24'd0, tx_log[(tx0 + 1) % 16]}, 32'hBE);
        wait_cycles(20);
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h44);
        wait_cycles(3);
        check("disc_wr_count", wr_cnt - wr0, 32'd1);
        check("disc_wr_addr", {28'd0, wr_addr_log[wr0 % 16]}, 32'h3);
        check("disc_wr_data", {24'd0, wr_data_log[wr0 % 16]}, 32'h44);

        // Global strobe properties over the whole run
        check("strobe_overlap", overlap_cnt, 32'd0);
        check("tx_while_busy", tx_busy_viol, 32'd0);
        check("alu_en_without_clk_en", alu_no_clken, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
